// File: rtl/button_conditioner.sv
// Per-channel button conditioner: 2-flop synchroniser, stability-count debounce,
// registered rise/fall edge pulses and long-press detection with optional auto-repeat.
module button_conditioner #(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 4,
    parameter int HOLD_CNT   = 190,
    parameter int REPEAT_CNT = 0
) (
    input  logic            clk190,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(HOLD_CNT + 1);
    localparam int RW = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CNT);
    localparam logic [RW-1:0] REP_LAST    = RW'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);
    localparam logic          REP_EN      = (REPEAT_CNT > 0);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic          s1_q, s2_q;
        logic          level_q, level_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic          lp_q, lp_d;
        logic          rep_on_q, rep_on_d;
        logic [SW-1:0] stab_q, stab_d;
        logic [HW-1:0] hold_q, hold_d;
        logic [RW-1:0] rep_q, rep_d;

        always_comb begin
            level_d  = level_q;
            stab_d   = stab_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            hold_d   = hold_q;
            rep_d    = rep_q;
            rep_on_d = rep_on_q;
            lp_d     = 1'b0;

            // Any sample matching the accepted level restarts the stability count.
            if (s2_q == level_q) begin
                stab_d = '0;
            end else if (stab_q == STABLE_LAST) begin
                level_d = s2_q;
                stab_d  = '0;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                stab_d = stab_q + SW'(1);
            end

            // Hold timing counts from the cycle after rise; a fall clears it on its own edge.
            if (!level_q || !level_d) begin
                hold_d   = '0;
                rep_d    = '0;
                rep_on_d = 1'b0;
            end else if (hold_q == HOLD_LAST) begin
                hold_d   = HOLD_MAX;
                lp_d     = 1'b1;
                rep_d    = '0;
                rep_on_d = REP_EN;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end else if (rep_on_q) begin
                if (rep_q == REP_LAST) begin
                    rep_d = '0;
                    lp_d  = 1'b1;
                end else begin
                    rep_d = rep_q + RW'(1);
                end
            end
        end

        always_ff @(posedge clk190 or posedge rst) begin
            if (rst) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                lp_q     <= 1'b0;
                rep_on_q <= 1'b0;
                stab_q   <= '0;
                hold_q   <= '0;
                rep_q    <= '0;
            end else begin
                s1_q     <= din[g];
                s2_q     <= s1_q;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                lp_q     <= lp_d;
                rep_on_q <= rep_on_d;
                stab_q   <= stab_d;
                hold_q   <= hold_d;
                rep_q    <= rep_d;
            end
        end

        assign level[g]      = level_q;
        assign rise[g]       = rise_q;
        assign fall[g]       = fall_q;
        assign long_press[g] = lp_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: debounce latency, glitch rejection,
// long-press timing (single and auto-repeat), bounce handling and async reset.
module tb_button_conditioner;

    logic       clk190 = 1'b0;
    logic       rst;
    logic [3:0] din, din_r;
    logic [3:0] level, rise, fall, lp;
    logic [3:0] level_r, rise_r, fall_r, lp_r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk190 = ~clk190;

    button_conditioner dut (
        .clk190     (clk190),
        .rst        (rst),
        .din        (din),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .long_press (lp)
    );

    button_conditioner #(.REPEAT_CNT(19)) dut_rep (
        .clk190     (clk190),
        .rst        (rst),
        .din        (din_r),
        .level      (level_r),
        .rise       (rise_r),
        .fall       (fall_r),
        .long_press (lp_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk190);
            #1;
        end
    endtask

    initial begin
        int lp_first, lp_n, both, fall_at, dev, nrise, rise_step, acc;
        int bseq[9];
        logic exp_lp;

        rst   = 1'b1;
        din   = '0;
        din_r = '0;
        #12;
        check("rst_level", level, 4'h0);
        check("rst_rise", rise, 4'h0);
        check("rst_fall", fall, 4'h0);
        check("rst_lp", lp, 4'h0);
        check("rst_level_r", level_r, 4'h0);
        step(2);
        rst = 1'b0;
        step(3);

        // Clean press and release on channel 0
        din = 4'b0001;
        step(5);
        check("lat_level_e4", level, 4'h0);
        step(1);
        check("lat_level_e5", level, 4'h1);
        check("lat_rise_e5", rise, 4'h1);
        step(1);
        check("lat_rise_e6", rise, 4'h0);
        check("lat_level_e6", level, 4'h1);
        din = 4'b0000;
        step(5);
        check("rel_fall_e4", fall, 4'h0);
        step(1);
        check("rel_fall_e5", fall, 4'h1);
        check("rel_level_e5", level, 4'h0);
        step(1);
        check("rel_fall_e6", fall, 4'h0);

        // Short 3-cycle pulse on channel 1 must be rejected
        din[1] = 1'b1;
        step(3);
        din[1] = 1'b0;
        acc = 0;
        repeat (12) begin
            step(1);
            if (level[1] || rise[1] || fall[1]) acc++;
        end
        check("glitch_ch1", acc, 0);

        // Long hold on channel 2, no repeat
        din[2] = 1'b1;
        step(6);
        check("hold_rise", rise, 4'b0100);
        lp_first = -1;
        lp_n = 0;
        both = 0;
        for (int i = 1; i <= 194; i++) begin
            step(1);
            if (lp[2]) begin
                lp_n++;
                if (lp_first < 0) lp_first = i;
            end
            if ((lp & rise) != 0) both++;
        end
        check("hold_lp_at", lp_first, 190);
        check("hold_lp_rise_overlap", both, 0);
        din[2] = 1'b0;
        fall_at = -1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (lp[2]) lp_n++;
            if (fall[2] && fall_at < 0) fall_at = i;
        end
        check("hold_fall_at", fall_at, 6);
        check("hold_lp_count", lp_n, 1);

        // Auto-repeat on the second instance, channel 3
        din_r[3] = 1'b1;
        step(6);
        check("rep_rise", rise_r, 4'b1000);
        dev = 0;
        lp_n = 0;
        for (int i = 1; i <= 250; i++) begin
            step(1);
            exp_lp = (i == 190) || (i == 209) || (i == 228) || (i == 247);
            if (lp_r[3]) lp_n++;
            if (lp_r[3] !== exp_lp) dev++;
        end
        check("rep_timing_dev", dev, 0);
        check("rep_count", lp_n, 4);
        din_r[3] = 1'b0;
        step(6);
        check("rep_fall", fall_r, 4'b1000);
        check("rep_level_off", level_r, 4'h0);

        // Bouncing press on channel 0
        bseq = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        nrise = 0;
        rise_step = -1;
        for (int j = 0; j < 20; j++) begin
            if (j < 9) din[0] = (bseq[j] != 0);
            step(1);
            if (rise[0]) begin
                nrise++;
                if (rise_step < 0) rise_step = j + 1;
            end
        end
        check("bounce_rise_step", rise_step, 11);
        check("bounce_rise_count", nrise, 1);
        check("bounce_level", level, 4'h1);
        din[0] = 1'b0;
        step(8);
        check("bounce_released", level, 4'h0);

        // Asynchronous reset mid-press
        din = 4'b1111;
        step(6);
        check("pre_rst_level", level, 4'hf);
        check("pre_rst_rise", rise, 4'hf);
        #2;
        rst = 1'b1;
        #1;
        check("arst_level", level, 4'h0);
        check("arst_rise", rise, 4'h0);
        check("arst_fall", fall, 4'h0);
        check("arst_lp", lp, 4'h0);
        step(3);
        check("arst_hold_level", level, 4'h0);
        check("arst_hold_fall", fall, 4'h0);
        rst = 1'b0;
        step(5);
        check("post_rst_level_e4", level, 4'h0);
        check("post_rst_fall_e4", fall, 4'h0);
        step(1);
        check("post_rst_rise_e5", rise, 4'hf);
        check("post_rst_level_e5", level, 4'hf);
        step(1);
        check("post_rst_rise_e6", rise, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
